// File: rtl/pio_edge_in.sv
// Avalon-MM parallel input port: per-bit synchroniser and optional debounce, followed by
// rising/falling edge capture into sticky write-1-to-clear flags with a masked level interrupt.
module pio_edge_in #(
    parameter int WIDTH       = 10,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_bit;
    logic [WIDTH-1:0] stable_val;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   stable_bit_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_port[gi]};
                end
            end

            assign sync_bit[gi]   = sync_reg[SYNC_STAGES-1];
            assign stable_val[gi] = stable_bit_reg;

            if (DEB_CYCLES == 0) begin : g_nodeb
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        stable_bit_reg <= 1'b0;
                    end else begin
                        stable_bit_reg <= sync_bit[gi];
                    end
                end
            end else begin : g_deb
                localparam logic [16:0] DEB_LAST = 17'(DEB_CYCLES);
                logic [15:0] cnt_reg;

                // Counter tracks consecutive cycles of disagreement; any agreement restarts it.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        cnt_reg        <= '0;
                        stable_bit_reg <= 1'b0;
                    end else if (sync_bit[gi] == stable_bit_reg) begin
                        cnt_reg <= '0;
                    end else if (({1'b0, cnt_reg} + 17'd1) == DEB_LAST) begin
                        cnt_reg        <= '0;
                        stable_bit_reg <= sync_bit[gi];
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
            end
        end
    endgenerate

    logic [WIDTH-1:0] prev_reg;
    logic [WIDTH-1:0] rise_en_reg, rise_en_next;
    logic [WIDTH-1:0] fall_en_reg, fall_en_next;
    logic [WIDTH-1:0] mask_reg, mask_next;
    logic [WIDTH-1:0] cap_reg, cap_next;
    logic [31:0]      readdata_reg, readdata_next;
    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] cap_clr;

    wire unused_wdata = &{1'b0, writedata};

    assign wr_en = chipselect && !write_n;
    assign wdata = writedata[WIDTH-1:0];

    // prev_reg resets alongside stable, so no edge can appear in the first cycle after reset.
    assign edge_set = (stable_val & ~prev_reg & rise_en_reg)
                    | (~stable_val & prev_reg & fall_en_reg);

    always_comb begin
        rise_en_next = rise_en_reg;
        fall_en_next = fall_en_reg;
        mask_next    = mask_reg;
        cap_clr      = '0;
        if (wr_en) begin
            case (address)
                3'd1:    rise_en_next = wdata;
                3'd2:    mask_next    = wdata;
                3'd3:    cap_clr      = wdata;
                3'd4:    fall_en_next = wdata;
                default: ;
            endcase
        end
        // Set takes priority over a simultaneous write-1-to-clear.
        cap_next = (cap_reg & ~cap_clr) | edge_set;
    end

    always_comb begin
        readdata_next = '0;
        case (address)
            3'd0:    readdata_next[WIDTH-1:0] = stable_val;
            3'd1:    readdata_next[WIDTH-1:0] = rise_en_reg;
            3'd2:    readdata_next[WIDTH-1:0] = mask_reg;
            3'd3:    readdata_next[WIDTH-1:0] = cap_reg;
            3'd4:    readdata_next[WIDTH-1:0] = fall_en_reg;
            default: readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_reg     <= '0;
            rise_en_reg  <= '0;
            fall_en_reg  <= '0;
            mask_reg     <= '0;
            cap_reg      <= '0;
            readdata_reg <= '0;
        end else begin
            prev_reg     <= stable_val;
            rise_en_reg  <= rise_en_next;
            fall_en_reg  <= fall_en_next;
            mask_reg     <= mask_next;
            cap_reg      <= cap_next;
            readdata_reg <= readdata_next;
        end
    end

    assign readdata = readdata_reg;
    assign irq      = |(cap_reg & mask_reg);

endmodule

// File: tb/tb_pio_edge_in.sv
// Directed bench for pio_edge_in: one undebounced instance and one with DEB_CYCLES=4
// sharing the bus, each with its own input pins.
module tb_pio_edge_in;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [9:0]  in0;
    logic [9:0]  in4;
    logic [31:0] rd0;
    logic [31:0] rd4;
    logic        irq0;
    logic        irq4;

    int total;
    int bad;

    pio_edge_in #(.WIDTH(10), .SYNC_STAGES(2), .DEB_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in0),
        .readdata(rd0), .irq(irq0)
    );

    pio_edge_in #(.WIDTH(10), .SYNC_STAGES(2), .DEB_CYCLES(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in4),
        .readdata(rd4), .irq(irq4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [2:0] a);
        address = a;
        tick(1);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in0        = '0;
        in4        = '0;

        #12;
        chk("reset_readdata", rd0, 32'h0);
        chk("reset_irq", {31'b0, irq0}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick(1);

        // DATA latency: sync (2) + stable register + readdata register
        address = 3'd0;
        in0     = 10'h155;
        tick(3);
        chk("data_before_latency", rd0, 32'h0);
        tick(1);
        chk("data_latency", rd0, 32'h155);

        in0 = 10'h000;
        tick(5);
        wr(3'd1, 32'h001);
        wr(3'd2, 32'h001);
        in0 = 10'h001;
        tick(5);
        rd(3'd3);
        chk("rise_cap", rd0, 32'h001);
        chk("rise_irq", {31'b0, irq0}, 32'h1);
        wr(3'd3, 32'h001);
        rd(3'd3);
        chk("w1c_cap", rd0, 32'h0);
        chk("w1c_irq", {31'b0, irq0}, 32'h0);

        wr(3'd4, 32'h200);
        wr(3'd2, 32'h000);
        in0 = 10'h201;
        tick(5);
        in0 = 10'h001;
        tick(5);
        rd(3'd3);
        chk("fall_cap", rd0, 32'h200);
        chk("fall_irq_masked", {31'b0, irq0}, 32'h0);
        wr(3'd2, 32'h200);
        chk("fall_irq_unmasked", {31'b0, irq0}, 32'h1);
        wr(3'd3, 32'h3FF);

        // Enabling rise on an already-high bit must not capture
        wr(3'd1, 32'h3FF);
        tick(3);
        rd(3'd3);
        chk("enable_no_cap", rd0, 32'h0);

        wr(3'd1, 32'h0000_0ABC);
        rd(3'd1);
        chk("rise_en_trunc", rd0, 32'h2BC);
        wr(3'd5, 32'hFFFF_FFFF);
        rd(3'd5);
        chk("off5_zero", rd0, 32'h0);
        wr(3'd0, 32'h3FF);
        rd(3'd0);
        chk("data_ro", rd0, 32'h001);

        // Set on bit2 lands on the same edge as a W1C of bits 2 and 5
        wr(3'd1, 32'h024);
        in0 = 10'h021;
        tick(5);
        rd(3'd3);
        chk("bit5_cap", rd0, 32'h020);
        in0 = 10'h025;
        tick(3);
        wr(3'd3, 32'h024);
        rd(3'd3);
        chk("set_wins_clear", rd0, 32'h004);
        wr(3'd3, 32'h3FF);

        // Debounce: 3-cycle pulse rejected, long hold accepted
        wr(3'd1, 32'h008);
        in4 = 10'h008;
        tick(3);
        in4 = 10'h000;
        tick(10);
        rd(3'd0);
        chk("deb_short_data", rd4, 32'h0);
        rd(3'd3);
        chk("deb_short_cap", rd4, 32'h0);
        in4 = 10'h008;
        tick(12);
        rd(3'd0);
        chk("deb_long_data", rd4, 32'h008);
        rd(3'd3);
        chk("deb_long_cap", rd4, 32'h008);

        // Fill every capture bit, then reset asynchronously
        wr(3'd1, 32'h3FF);
        wr(3'd4, 32'h3FF);
        in0 = in0 ^ 10'h3FF;
        tick(5);
        wr(3'd2, 32'h3FF);
        rd(3'd3);
        chk("cap_all", rd0, 32'h3FF);
        chk("irq_all", {31'b0, irq0}, 32'h1);
        reset_n = 1'b0;
        in0     = 10'h3FF;
        #2;
        chk("async_irq", {31'b0, irq0}, 32'h0);
        chk("async_readdata", rd0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick(8);
        rd(3'd1);
        chk("post_rise_en", rd0, 32'h0);
        rd(3'd2);
        chk("post_mask", rd0, 32'h0);
        rd(3'd3);
        chk("post_cap", rd0, 32'h0);
        rd(3'd4);
        chk("post_fall_en", rd0, 32'h0);
        rd(3'd0);
        chk("post_data", rd0, 32'h3FF);
        chk("post_irq", {31'b0, irq0}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
